// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the rv32i pipeline. Owns the architectural fetch
// PC (PCF), which feeds the IF/ID pipeline register and the instruction-cache
// lookup. The next PC comes from one of three sources:
//   - the sequential increment PCF+4,
//   - a live execute-stage redirect (PCSrcE/PCTargetE), or
//   - a redirect captured while fetch was stalled, replayed on the first
//     unstalled edge so that it is never lost.
// A redirect target whose low two bits are nonzero is loaded word-aligned and
// flagged on misalignF. fetch_cnt counts every edge on which PCF advances.
//
// Ports:
//   clk          in   1         rising-edge clock
//   rst          in   1         synchronous active-high reset
//   stallF       in   1         hazard-unit stall; PCF holds while high
//   PCSrcE       in   1         execute-stage redirect request (1-cycle pulse)
//   PCTargetE    in   DPW       redirect target, meaningful when PCSrcE=1
//   PCF          out  DPW       current fetch PC (registered)
//   PCPlus4F     out  DPW       PCF+4, combinational, wraps modulo 2^DPW
//   redir_pendF  out  1         redirect latched, awaiting un-stall (registered)
//   misalignF    out  1         PCF came from a target with nonzero [1:0]
//   fetch_cnt    out  CntWidth  PC advances since reset (registered)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned       DPW         = 32,   // datapath / PC width
    parameter logic [DPW-1:0]    ResetVector = '0,   // bits [1:0] must be zero
    parameter int unsigned       CntWidth    = 32    // fetch counter width
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallF,
    input  logic                PCSrcE,
    input  logic [DPW-1:0]      PCTargetE,
    output logic [DPW-1:0]      PCF,
    output logic [DPW-1:0]      PCPlus4F,
    output logic                redir_pendF,
    output logic                misalignF,
    output logic [CntWidth-1:0] fetch_cnt
);

    // Redirect bookkeeping: IDLE means no redirect is waiting, PEND means one
    // was captured during a stall and will be taken on the next free edge.
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } redir_state_e;

    redir_state_e           state_q;
    logic [DPW-1:0]         pend_tgt_q;   // raw target as captured, unaligned
    logic [DPW-1:0]         pc_q;
    logic                   misalign_q;
    logic [CntWidth-1:0]    cnt_q;

    // -----------------------------------------------------------------------
    // Next-PC source selection
    // -----------------------------------------------------------------------
    logic                   take_tgt;     // PCF loads from a target this edge
    logic [DPW-1:0]         sel_tgt;      // raw chosen target
    logic [DPW-1:0]         aligned_tgt;
    logic [DPW-1:0]         pc_plus4;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        take_tgt    = 1'b0;
        sel_tgt     = pend_tgt_q;
        // A live redirect always beats a pending one: it is younger in
        // program order and supersedes whatever was captured earlier.
        if (PCSrcE) begin
            take_tgt = 1'b1;
            sel_tgt  = PCTargetE;
        end else if (state_q == PEND) begin
            take_tgt = 1'b1;
            sel_tgt  = pend_tgt_q;
        end
        aligned_tgt = {sel_tgt[DPW-1:2], 2'b00};
        // Plain modular add: 0xFFFF_FFFC + 4 wraps to 0.
        pc_plus4    = pc_q + DPW'(4);
    end

    // -----------------------------------------------------------------------
    // PC, redirect state machine, alignment flag and fetch counter
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset wins over everything, including a pending redirect.
            pc_q       <= ResetVector;
            state_q    <= IDLE;
            pend_tgt_q <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else if (!stallF) begin
            // PC advances: from a target (live or pending) or sequentially.
            if (take_tgt) begin
                pc_q       <= aligned_tgt;
                misalign_q <= |sel_tgt[1:0];
            end else begin
                pc_q       <= pc_plus4;
                misalign_q <= 1'b0;
            end
            // Any pending redirect has now been consumed or overridden.
            state_q    <= IDLE;
            pend_tgt_q <= '0;
            cnt_q      <= cnt_q + CntWidth'(1);
        end else begin
            // Stalled: PC, alignment flag and counter hold. A redirect seen
            // now is captured; a newer one overwrites an older one.
            case (state_q)
                IDLE: begin
                    if (PCSrcE) begin
                        state_q    <= PEND;
                        pend_tgt_q <= PCTargetE;
                    end
                end
                PEND: begin
                    if (PCSrcE) begin
                        pend_tgt_q <= PCTargetE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    pend_tgt_q <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign PCF         = pc_q;
    assign PCPlus4F    = pc_plus4;
    assign redir_pendF = (state_q == PEND);
    assign misalignF   = misalign_q;
    assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Inputs are driven 1 time unit after each
// rising edge and outputs are sampled at the same point, away from the edge.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int unsigned DPW      = 32;
    localparam int unsigned CntWidth = 32;

    logic                clk;
    logic                rst;
    logic                stallF;
    logic                PCSrcE;
    logic [DPW-1:0]      PCTargetE;
    logic [DPW-1:0]      PCF;
    logic [DPW-1:0]      PCPlus4F;
    logic                redir_pendF;
    logic                misalignF;
    logic [CntWidth-1:0] fetch_cnt;

    int vectors;
    int miscompares;

    fetch_stage #(
        .DPW         (DPW),
        .ResetVector (32'h0000_0000),
        .CntWidth    (CntWidth)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallF      (stallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .redir_pendF (redir_pendF),
        .misalignF   (misalignF),
        .fetch_cnt   (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: wait for the rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full-state check shorthand.
    task automatic chk_all(input string tag, input logic [31:0] pc,
                           input logic pend, input logic mis,
                           input logic [31:0] cnt);
        chk({tag, ".pc"},   64'(PCF),         64'(pc));
        chk({tag, ".pend"}, 64'(redir_pendF), 64'(pend));
        chk({tag, ".mis"},  64'(misalignF),   64'(mis));
        chk({tag, ".cnt"},  64'(fetch_cnt),   64'(cnt));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        stallF    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = '0;
        #1;

        // Reset state.
        step();
        chk_all("reset", 32'h0, 1'b0, 1'b0, 32'd0);
        chk("reset.plus4", 64'(PCPlus4F), 64'h4);

        // Three free cycles: 0 -> 4 -> 8 -> C.
        rst = 1'b0;
        step();
        chk("free1.pc", 64'(PCF), 64'h4);
        step();
        chk_all("free2", 32'h8, 1'b0, 1'b0, 32'd2);
        step();
        chk_all("free3", 32'hC, 1'b0, 1'b0, 32'd3);
        chk("free3.plus4", 64'(PCPlus4F), 64'h10);

        // Unstalled redirect to 0x100, then sequential 0x104.
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        step();
        chk_all("redir", 32'h100, 1'b0, 1'b0, 32'd4);
        PCSrcE = 1'b0; PCTargetE = 32'h0;
        step();
        chk_all("redir+1", 32'h104, 1'b0, 1'b0, 32'd5);

        // Move to 0x20, then stall 3 cycles with a redirect in the 2nd.
        PCSrcE = 1'b1; PCTargetE = 32'h20;
        step();
        chk_all("to20", 32'h20, 1'b0, 1'b0, 32'd6);
        PCSrcE = 1'b0;
        stallF = 1'b1;
        step();
        chk_all("stall1", 32'h20, 1'b0, 1'b0, 32'd6);
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        step();
        chk_all("stall2", 32'h20, 1'b1, 1'b0, 32'd6);
        PCSrcE = 1'b0; PCTargetE = 32'hDEAD_BEEF;  // ignored: PCSrcE=0
        step();
        chk_all("stall3", 32'h20, 1'b1, 1'b0, 32'd6);
        stallF = 1'b0;
        step();
        chk_all("unstall", 32'h200, 1'b0, 1'b0, 32'd7);

        // Two pending redirects, then a live one at un-stall wins.
        stallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h300;
        step();
        PCTargetE = 32'h400;
        step();
        chk_all("pend400", 32'h200, 1'b1, 1'b0, 32'd7);
        stallF = 1'b0; PCTargetE = 32'h500;
        step();
        chk_all("live500", 32'h500, 1'b0, 1'b0, 32'd8);

        // Same again without the live redirect: newest pending (0x400) wins.
        stallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h300;
        step();
        PCTargetE = 32'h400;
        step();
        stallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        step();
        chk_all("pend_win", 32'h400, 1'b0, 1'b0, 32'd9);

        // Misaligned live redirect, then a sequential advance clears the flag.
        PCSrcE = 1'b1; PCTargetE = 32'h1002;
        step();
        chk_all("mis_live", 32'h1000, 1'b0, 1'b1, 32'd10);
        PCSrcE = 1'b0; PCTargetE = 32'h0;
        step();
        chk_all("mis_clr", 32'h1004, 1'b0, 1'b0, 32'd11);

        // Misaligned pending target: checked on the raw stored value.
        stallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h2003;
        step();
        stallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        step();
        chk_all("mis_pend", 32'h2000, 1'b0, 1'b1, 32'd12);
        // A plain stall holds the flag.
        stallF = 1'b1;
        step();
        chk_all("mis_hold", 32'h2000, 1'b0, 1'b1, 32'd12);

        // PC wrap at the top of the address space.
        stallF = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        step();
        chk_all("top", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd13);
        chk("top.plus4", 64'(PCPlus4F), 64'h0);
        PCSrcE = 1'b0; PCTargetE = 32'h0;
        step();
        chk_all("wrap", 32'h0, 1'b0, 1'b0, 32'd14);
        chk("wrap.plus4", 64'(PCPlus4F), 64'h4);

        // Reset during PEND discards the pending redirect.
        stallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h700;
        step();
        chk_all("pre_rst", 32'h0, 1'b1, 1'b0, 32'd14);
        rst = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'h0;
        step();
        chk_all("rst_pend", 32'h0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0; stallF = 1'b0;
        step();
        chk_all("post_rst", 32'h4, 1'b0, 1'b0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
